operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
//  Register-file read stage directly upstream of the ALU. Holds the 32x32 integer register file,
//  reads rs1/rs2, selects immediate vs rs2, and presents registered operation/operand_1/operand_2
//  to the ALU. Uses a valid/ready handshake with a 2-entry skid buffer so that in_ready is a
//  pure register output. Writeback writes the register file through a separate port.
// PARAMETERS
//  DATA_W     32  operand/register width (ALU is 32-bit; only 32 is supported)
//  REG_COUNT  32  architectural registers; x0 reads as zero
// PORTS
//  clk              in   1   single clock, all state on rising edge
//  reset            in   1   synchronous, active-high
//  in_valid         in   1   upstream presents an instruction
//  in_ready         out  1   stage accepts when in_valid && in_ready (registered output)
//  in_operation     in   3   ALU opcode (ALU_AND/ADD/SUB/OR/XOR from Defines.v)
//  in_rs1           in   5   source register 1 index
//  in_rs2           in   5   source register 2 index
//  in_immediate     in   32  immediate value
//  in_use_immediate in   1   1: operand_2 = in_immediate, 0: operand_2 = R[rs2]
//  wb_enable        in   1   register write strobe
//  wb_rd            in   5   write index; writes to x0 are discarded
//  wb_data          in   32  write data
//  out_valid        out  1   operands valid toward ALU
//  out_ready        in   1   ALU side consumes when out_valid && out_ready
//  operation        out  3   registered opcode to ALU
//  operand_1        out  32  registered R[rs1]
//  operand_2        out  32  registered R[rs2] or immediate
// BEHAVIOUR
//  Reset: out_valid=0, in_ready=1, operation=ALU_ADD, operand_1=operand_2=0, skid empty, all 32
//   registers cleared to 0; reset mid-operation drops held entries; writes during reset ignored.
//  Latency: accepted instruction appears on outputs the next cycle when stage was empty.
//  Operands sampled at the accepting edge; held entries are NOT refreshed by later writebacks.
//  States: EMPTY (main 0, skid 0), ONE (main 1, skid 0), TWO (main 1, skid 1).
//   EMPTY: accept -> ONE.  ONE: accept&&!consume -> TWO; consume&&!accept -> EMPTY; both -> ONE.
//   TWO: in_ready=0; consume -> skid moves to main, ONE.  Order strictly FIFO.
//  in_ready = (next state != TWO), registered; accept while in_ready=0 never happens.
//  out_valid/operation/operands stable while out_valid && !out_ready.
//  x0: reads always 0 regardless of writes; wb_rd=0 write has no effect.
//  Writeback takes effect at the clock edge; simultaneous write and accept to same index:
//   see CONFIGURATION.  Two sources same index read the same value.
// CONFIGURATION
//  OPERAND_FETCH_WRITE_BYPASS_EN defined: wb_enable && wb_rd==rs && rs!=0 in the accepting
//   cycle -> operand captures wb_data (write-first).
//  Not defined: operand captures pre-write register contents (read-first).
// STRUCTURE
//  Defines.v: ALU opcodes, ENABLE/DISABLE, REG_ADDR_W=5, stage state encodings.
//  Sub-module register_file: 32x32, 2 async read ports, 1 sync write port, x0 hard-wired 0,
//   synchronous clear on reset. Skid/handshake logic in operand_fetch_stage.
// TESTING
//  1 Write R5=0x0000_0010 R6=0x0000_0003; issue ADD rs1=5 rs2=6, out_ready=1
//    -> next cycle out_valid=1, operation=ALU_ADD, operand_1=0x10, operand_2=0x3.
//  2 Issue rs1=0 after wb_rd=0 wb_data=0xFFFF_FFFF -> operand_1=0; in_use_immediate=1
//    imm=0x0000_0ABC -> operand_2=0xABC.
//  3 out_ready=0, issue three back-to-back -> 2 accepted, in_ready=0 on 3rd; release out_ready
//    -> outputs in issue order, in_ready returns 1 after first consume.
//  4 Same-cycle wb R7=0x55 and accept rs1=7 (R7 was 0x11): operand_1=0x55 with
//    OPERAND_FETCH_WRITE_BYPASS_EN, 0x11 without.
//  5 Reset asserted in state TWO -> next cycle out_valid=0, in_ready=1, R7 reads 0.
//  6 Random valid/ready stress vs scoreboard model: no loss, duplication, or reordering.

Source files
------------

// File: rtl/operand_fetch_stage_pkg.sv
// ============================================================================
// Module   : operand_fetch_stage_pkg
// Brief    : Shared ALU opcodes, widths and stage state encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_fetch_stage_pkg;

    localparam int c_reg_addr_w = 5;
    localparam int c_alu_op_w   = 3;

    typedef enum logic [c_alu_op_w-1:0] {
        ALU_AND = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_t;

    // Occupancy of the main/skid pair
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

endpackage

`default_nettype wire

// File: rtl/operand_fetch_stage_register_file.sv
// ============================================================================
// Module   : operand_fetch_stage_register_file
// Brief    : Integer register file, 2 async read ports, 1 sync write port, x0 = 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch_stage_register_file
    import operand_fetch_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [c_reg_addr_w-1:0] rs1_addr,
    input  logic [c_reg_addr_w-1:0] rs2_addr,
    output logic [DATA_W-1:0]       rs1_data,
    output logic [DATA_W-1:0]       rs2_data,
    input  logic                    wr_enable,
    input  logic [c_reg_addr_w-1:0] wr_addr,
    input  logic [DATA_W-1:0]       wr_data
);

    logic [DATA_W-1:0] r_regs [REG_COUNT];

    // Clear has priority, so writes presented during reset are lost
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_enable && (wr_addr != '0)) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = (rs1_addr == '0) ? '0 : r_regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : r_regs[rs2_addr];

endmodule

`default_nettype wire

// File: rtl/operand_fetch_stage.sv
// ============================================================================
// Module   : operand_fetch_stage
// Brief    : Register read stage feeding the ALU; valid/ready with 2-entry skid.
// Config   : define OPERAND_FETCH_WRITE_BYPASS_EN for write-first operand capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [c_alu_op_w-1:0]   in_operation,
    input  logic [c_reg_addr_w-1:0] in_rs1,
    input  logic [c_reg_addr_w-1:0] in_rs2,
    input  logic [DATA_W-1:0]       in_immediate,
    input  logic                    in_use_immediate,
    input  logic                    wb_enable,
    input  logic [c_reg_addr_w-1:0] wb_rd,
    input  logic [DATA_W-1:0]       wb_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [c_alu_op_w-1:0]   operation,
    output logic [DATA_W-1:0]       operand_1,
    output logic [DATA_W-1:0]       operand_2
);

    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;
    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_src2;
    logic [DATA_W-1:0] w_new_op2;

    operand_fetch_stage_register_file #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT)
    ) u_register_file (
        .clk       (clk),
        .reset     (reset),
        .rs1_addr  (in_rs1),
        .rs2_addr  (in_rs2),
        .rs1_data  (w_rs1_data),
        .rs2_data  (w_rs2_data),
        .wr_enable (wb_enable),
        .wr_addr   (wb_rd),
        .wr_data   (wb_data)
    );

`ifdef OPERAND_FETCH_WRITE_BYPASS_EN
    // Forward a same-cycle writeback so the captured operand sees the new value
    assign w_src1 = (wb_enable && (wb_rd == in_rs1) && (in_rs1 != '0)) ? wb_data : w_rs1_data;
    assign w_src2 = (wb_enable && (wb_rd == in_rs2) && (in_rs2 != '0)) ? wb_data : w_rs2_data;
`else
    assign w_src1 = w_rs1_data;
    assign w_src2 = w_rs2_data;
`endif

    assign w_new_op2 = in_use_immediate ? in_immediate : w_src2;

    stage_state_t        r_state;
    stage_state_t        w_next_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [c_alu_op_w-1:0] r_main_op;
    logic [DATA_W-1:0]   r_main_op1;
    logic [DATA_W-1:0]   r_main_op2;
    logic [c_alu_op_w-1:0] r_skid_op;
    logic [DATA_W-1:0]   r_skid_op1;
    logic [DATA_W-1:0]   r_skid_op2;
    logic                w_accept;
    logic                w_consume;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;

    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_out_valid && out_ready;

    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next_state   = ST_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_consume) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_next_state = ST_TWO;
                    w_load_skid  = 1'b1;
                end else if (w_consume) begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_consume) begin
                    w_next_state     = ST_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_next_state = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_op   <= ALU_ADD;
            r_main_op1  <= '0;
            r_main_op2  <= '0;
            r_skid_op   <= ALU_ADD;
            r_skid_op1  <= '0;
            r_skid_op2  <= '0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state != ST_TWO);
            r_out_valid <= (w_next_state != ST_EMPTY);
            if (w_load_main_in) begin
                r_main_op  <= in_operation;
                r_main_op1 <= w_src1;
                r_main_op2 <= w_new_op2;
            end else if (w_load_main_skid) begin
                r_main_op  <= r_skid_op;
                r_main_op1 <= r_skid_op1;
                r_main_op2 <= r_skid_op2;
            end
            if (w_load_skid) begin
                r_skid_op  <= in_operation;
                r_skid_op1 <= w_src1;
                r_skid_op2 <= w_new_op2;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign operation = r_main_op;
    assign operand_1 = r_main_op1;
    assign operand_2 = r_main_op2;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
// ============================================================================
// Module   : tb_operand_fetch_stage
// Brief    : Directed and randomized self-checking bench for operand_fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch_stage;
    import operand_fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_operation;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_immediate;
    logic        in_use_immediate;
    logic        wb_enable;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  operation;
    logic [31:0] operand_1;
    logic [31:0] operand_2;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        q[$];
    exp_t        head;
    logic [31:0] reg_model [32];
    logic [31:0] exp_bypass;
    logic        accept;
    logic        consume;

    operand_fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_operation     (in_operation),
        .in_rs1           (in_rs1),
        .in_rs2           (in_rs2),
        .in_immediate     (in_immediate),
        .in_use_immediate (in_use_immediate),
        .wb_enable        (wb_enable),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .operation        (operation),
        .operand_1        (operand_1),
        .operand_2        (operand_2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [31:0] data);
        wb_enable = 1'b1;
        wb_rd     = rd;
        wb_data   = data;
        tick();
        wb_enable = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input logic use_imm);
        in_valid         = 1'b1;
        in_operation     = op;
        in_rs1           = rs1;
        in_rs2           = rs2;
        in_immediate     = imm;
        in_use_immediate = use_imm;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_operation = 3'd0; in_rs1 = '0; in_rs2 = '0;
        in_immediate = '0; in_use_immediate = 1'b0; wb_enable = 1'b0; wb_rd = '0;
        wb_data = '0; out_ready = 1'b0;
        for (int i = 0; i < 32; i++) reg_model[i] = '0;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_op",    32'(operation), 32'(ALU_ADD));
        chk("rst_op1",   operand_1, 32'd0);
        chk("rst_op2",   operand_2, 32'd0);
        reset = 1'b0;

        // Basic register ADD
        wr(5'd5, 32'h0000_0010);
        wr(5'd6, 32'h0000_0003);
        out_ready = 1'b1;
        issue(ALU_ADD, 5'd5, 5'd6, 32'h0, 1'b0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_op",    32'(operation), 32'(ALU_ADD));
        chk("t1_op1",   operand_1, 32'h10);
        chk("t1_op2",   operand_2, 32'h3);
        tick();
        chk("t1_drain", 32'(out_valid), 32'd0);

        // x0 and immediate select, then same source twice
        wr(5'd0, 32'hFFFF_FFFF);
        issue(ALU_OR, 5'd0, 5'd0, 32'h0000_0ABC, 1'b1);
        chk("t2_x0",  operand_1, 32'h0);
        chk("t2_imm", operand_2, 32'hABC);
        chk("t2_opc", 32'(operation), 32'(ALU_OR));
        issue(ALU_XOR, 5'd5, 5'd5, 32'h0, 1'b0);
        chk("t2_same1", operand_1, 32'h10);
        chk("t2_same2", operand_2, 32'h10);
        tick();

        // Backpressure fills the skid, third instruction is refused
        wr(5'd1, 32'h101); wr(5'd2, 32'h202); wr(5'd3, 32'h303);
        out_ready = 1'b0;
        in_valid = 1'b1; in_use_immediate = 1'b0; in_rs2 = 5'd0;
        in_operation = ALU_AND; in_rs1 = 5'd1;
        tick();
        chk("t3_rdy1", 32'(in_ready), 32'd1);
        chk("t3_a1",   operand_1, 32'h101);
        in_operation = ALU_SUB; in_rs1 = 5'd2;
        tick();
        chk("t3_rdy2",  32'(in_ready), 32'd0);
        chk("t3_hold1", operand_1, 32'h101);
        in_operation = ALU_XOR; in_rs1 = 5'd3;
        tick();
        chk("t3_rdy3",  32'(in_ready), 32'd0);
        chk("t3_hold2", operand_1, 32'h101);
        chk("t3_hopc",  32'(operation), 32'(ALU_AND));
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("t3_b1",   operand_1, 32'h202);
        chk("t3_bopc", 32'(operation), 32'(ALU_SUB));
        chk("t3_rdy4", 32'(in_ready), 32'd1);
        tick();
        chk("t3_empty", 32'(out_valid), 32'd0);

        // Same-cycle writeback and accept on R7
        wr(5'd7, 32'h11);
`ifdef OPERAND_FETCH_WRITE_BYPASS_EN
        exp_bypass = 32'h55;
`else
        exp_bypass = 32'h11;
`endif
        wb_enable = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
        issue(ALU_ADD, 5'd7, 5'd0, 32'h0, 1'b0);
        wb_enable = 1'b0;
        chk("t4_bypass", operand_1, exp_bypass);
        issue(ALU_ADD, 5'd7, 5'd0, 32'h0, 1'b0);
        chk("t4_after", operand_1, 32'h55);
        tick();

        // Reset while two entries are held; a write during reset is dropped
        out_ready = 1'b0;
        in_valid = 1'b1; in_rs1 = 5'd7;
        tick(); tick();
        in_valid = 1'b0;
        chk("t5_full", 32'(in_ready), 32'd0);
        reset = 1'b1; wb_enable = 1'b1; wb_rd = 5'd8; wb_data = 32'h99;
        tick();
        reset = 1'b0; wb_enable = 1'b0;
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        issue(ALU_ADD, 5'd7, 5'd8, 32'h0, 1'b0);
        chk("t5_r7", operand_1, 32'h0);
        chk("t5_r8", operand_2, 32'h0);
        tick();

        // Randomized handshake stress against a FIFO model
        for (int i = 1; i < 32; i++) begin
            reg_model[i] = (32'(i) * 32'h0101_0101) ^ 32'hA500_0000;
            wr(5'(i), reg_model[i]);
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid         = 1'($urandom_range(0, 1));
            out_ready        = ($urandom_range(0, 3) != 0);
            in_operation     = 3'($urandom_range(0, 4));
            in_rs1           = 5'($urandom_range(0, 31));
            in_rs2           = 5'($urandom_range(0, 31));
            in_immediate     = $urandom;
            in_use_immediate = 1'($urandom_range(0, 1));
            accept  = in_valid && (q.size() < 2);
            consume = (q.size() != 0) && out_ready;
            if (consume) begin
                head = q.pop_front();
                chk("t6_opc", 32'(operation), 32'(head.op));
                chk("t6_op1", operand_1, head.a);
                chk("t6_op2", operand_2, head.b);
            end
            if (accept) begin
                q.push_back({in_operation, reg_model[in_rs1],
                             in_use_immediate ? in_immediate : reg_model[in_rs2]});
            end
            tick();
            chk("t6_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("t6_ready", 32'(in_ready), 32'(q.size() < 2));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (q.size() != 0) begin
                head = q.pop_front();
                chk("t6_dop1", operand_1, head.a);
                chk("t6_dop2", operand_2, head.b);
            end
            tick();
        end
        chk("t6_left", 32'(q.size()), 32'd0);
        chk("t6_idle", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
